// File: rtl/proc_pkg.sv
// Shared constants and sweep state type for the memory readout scanner.
package proc_pkg;

    localparam int unsigned RW = 24;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO with occupancy count; the top bit of each entry carries the end-of-sweep tag.
module readout_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_readout_scanner.sv
// Sweeps a block of the memory's inspection port and streams the words out over valid/ready,
// using read credits so in-flight reads always have a FIFO slot waiting for them.
module mem_readout_scanner
    import proc_pkg::*;
#(
    parameter int unsigned AW     = RW,
    parameter int unsigned DW     = RW,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    if (DEPTH < RD_LAT + 2) begin : g_depth_check
        $error("readout FIFO DEPTH must be at least RD_LAT+2");
    end

    scan_state_t   state;
    scan_state_t   next_state;
    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] issued;
    logic [AW-1:0] issue_addr;
    logic          issue;
    logic          issue_last;
    logic          credit;
    logic [RD_LAT:0] rd_v;
    logic [RD_LAT:0] rd_last;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [DW:0]   head;
    logic          fifo_empty;
    logic          pop;
    logic          push;

    assign credit    = (SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH);
    assign push      = rd_v[RD_LAT];
    assign out_valid = !fifo_empty;
    assign out_data  = head[DW-1:0];
    assign out_last  = head[DW] && !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The first read is issued on the accepting edge so addr shows base_addr one cycle after start.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = base_q + issued;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        next_state = DONE;
                    end else begin
                        next_state = SCAN;
                        issue      = 1'b1;
                        issue_addr = base_addr;
                        issue_last = (length == AW'(1));
                    end
                end
            end
            SCAN: begin
                if (issued == len_q) begin
                    next_state = DRAIN;
                end else if (credit) begin
                    issue      = 1'b1;
                    issue_last = (issued == len_q - AW'(1));
                end
            end
            DRAIN: begin
                if (pop && head[DW]) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            rd_v     <= '0;
            rd_last  <= '0;
            inflight <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= length;
            end
            if (issue) begin
                addr   <= issue_addr;
                issued <= (state == IDLE) ? AW'(1) : issued + AW'(1);
            end else if (state == IDLE) begin
                issued <= '0;
            end
            // rd_v[0] marks a live address; rd_v[RD_LAT] marks q holding its word.
            rd_v    <= {rd_v[RD_LAT-1:0], issue};
            rd_last <= {rd_last[RD_LAT-1:0], issue_last};
            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == SCAN) || (next_state == DRAIN);
            done <= (next_state == DONE);
        end
    end

    readout_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({rd_last[RD_LAT], q}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mem_readout_scanner.sv
// Randomized scoreboard bench: sweeps are predicted from base/length arithmetic, a monitor checks the stream.
module tb_mem_readout_scanner;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 24;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic [AW-1:0] addr;
    logic [DW-1:0] q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;

    word_t         exp_q[$];
    logic [AW-1:0] exp_addr[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int hs_cnt = 0;
    int last_hs_cyc = -1;
    int max_fill = 0;
    int ready_mode = 0;
    logic [AW-1:0] last_addr = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    mem_readout_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .addr      (addr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return DW'(a * 3);
    endfunction

    // Synchronous memory with one cycle of read latency.
    always @(posedge clk) q <= mem_val(addr);

    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: address sequence, output hold under stall, data/last scoreboard, done pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_addr  = '0;
            stall_prev = 1'b0;
        end else begin
            if (int'(dut.u_fifo.count) > max_fill) max_fill = int'(dut.u_fifo.count);
            if (addr != last_addr) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL addr_seq: addr changed to %h, required no change", addr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_addr.pop_front();
                    if (addr !== ea) begin
                        errors++;
                        $display("FAIL addr_seq: addr=%h required %h", addr, ea);
                    end
                end
                last_addr = addr;
            end
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_data !== stall_data) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, stall_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected word %h last=%b, required none", out_data, out_last);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    if (out_data !== w.data || out_last !== w.last) begin
                        errors++;
                        $display("FAIL stream: data=%h last=%b required data=%h last=%b", out_data, out_last, w.data, w.last);
                    end
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic start_sweep(input logic [AW-1:0] b, input logic [AW-1:0] n, output int st);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        for (int i = 0; i < int'(n); i++) begin
            word_t         w;
            logic [AW-1:0] a;
            a = b + AW'(i);
            w.data = mem_val(a);
            w.last = (i == int'(n) - 1);
            exp_q.push_back(w);
            exp_addr.push_back(a);
        end
        @(posedge clk);
        #1;
        st    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b pending=%0d required idle and drained", name, busy, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int st;
        int c3;
        int d0;
        int h0;
        int t;
        logic [AW-1:0] b;
        logic [AW-1:0] n;

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        #12;
        chk("reset_addr", 32'(addr), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_last", 32'(out_last), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        #10;
        rst = 1'b0;

        // Basic sweep with latency and completion timing.
        ready_mode = 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        start_sweep(24'h000010, 24'd4, st);
        @(negedge clk);
        chk("basic_addr_cycle1", 32'(addr), 32'h10);
        @(negedge clk);
        chk("basic_valid_cycle2", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("basic_valid_cycle3", 32'(out_valid), 32'h1);
        c3 = cyc;
        wait_idle("basic");
        chk("basic_words", 32'(hs_cnt - h0), 32'd4);
        chk("basic_back_to_back", 32'(last_hs_cyc - c3), 32'd3);
        chk("basic_done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("basic_done_count", 32'(done_cnt - d0), 32'd1);

        // Zero-length sweep: done only.
        d0 = done_cnt;
        start_sweep(24'h000777, 24'd0, st);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("len0_busy", 32'(busy), 32'h0);
            chk("len0_valid", 32'(out_valid), 32'h0);
        end
        chk("len0_done_count", 32'(done_cnt - d0), 32'd1);
        chk("len0_done_cycle", 32'(done_cyc), 32'(st));

        // Backpressure with a 1,0,0,1 ready pattern.
        ready_mode = 1;
        max_fill = 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        start_sweep(24'h000200, 24'd10, st);
        wait_idle("backpressure");
        chk("bp_words", 32'(hs_cnt - h0), 32'd10);
        chk("bp_fill_within_depth", 32'(max_fill <= 4), 32'h1);
        chk("bp_done_count", 32'(done_cnt - d0), 32'd1);

        // Address wrap.
        ready_mode = 0;
        d0 = done_cnt;
        start_sweep(24'hFFFFFE, 24'd4, st);
        wait_idle("wrap");
        chk("wrap_final_addr", 32'(addr), 32'h000001);
        chk("wrap_done_count", 32'(done_cnt - d0), 32'd1);

        // A second start during a sweep must be ignored.
        ready_mode = 2;
        d0 = done_cnt;
        start_sweep(24'h012300, 24'd12, st);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 24'h0F0000;
        length = 24'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("restart_ignored");
        chk("restart_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset after two of eight words.
        ready_mode = 0;
        h0 = hs_cnt;
        start_sweep(24'h0ABC00, 24'd8, st);
        t = 0;
        while (hs_cnt < h0 + 2 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("rst_mid_reached_word2", 32'(hs_cnt - h0 >= 2), 32'h1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_last", 32'(out_last), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_addr", 32'(addr), 32'h0);
        exp_q.delete();
        exp_addr.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_done_low", 32'(done), 32'h0);
        end
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        h0 = hs_cnt;
        start_sweep(24'h0ABC00, 24'd8, st);
        wait_idle("post_reset");
        chk("post_reset_words", 32'(hs_cnt - h0), 32'd8);
        chk("post_reset_done_count", 32'(done_cnt - d0), 32'd1);

        // Randomized sweeps.
        for (int k = 0; k < 20; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            n = AW'($urandom_range(0, 20));
            do begin
                b = AW'($urandom);
            end while (b == '0 || b == addr);
            d0 = done_cnt;
            h0 = hs_cnt;
            start_sweep(b, n, st);
            wait_idle("random");
            chk("random_words", 32'(hs_cnt - h0), 32'(n));
            chk("random_done_count", 32'(done_cnt - d0), 32'd1);
        end

        chk("final_stream_drained", 32'(exp_q.size()), 32'd0);
        chk("final_addr_drained", 32'(exp_addr.size()), 32'd0);
        chk("final_fill_within_depth", 32'(max_fill <= 4), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
